// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: byte-burst sequencer for an SPI byte engine.
// Bytes queued in a TX FIFO are handed to the engine one at a time. A go/len
// request runs a burst of len bytes, and seq_done pulses once when it ends.
// Optional RX path: define SPI_XFER_SEQ_RX_FIFO_EN to build the RX FIFO and
// the sticky overflow flag. Without it, received bytes are dropped and the RX
// outputs are tied to zero.
module spi_xfer_seq #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // TX FIFO write port
    input  logic             tx_wr_valid,
    input  logic [7:0]       tx_wr_data,
    output logic             tx_wr_ready,
    // RX FIFO read port, first-word-fall-through
    output logic             rx_rd_valid,
    output logic [7:0]       rx_rd_data,
    input  logic             rx_rd_ready,
    // burst request
    input  logic             go,
    input  logic [LEN_W-1:0] len,
    output logic             seq_busy,
    output logic             seq_done,
    output logic             rx_ovf,
    // byte engine
    output logic             m_start,
    output logic [7:0]       m_tx_data,
    input  logic             m_busy,
    input  logic             m_done,
    input  logic [7:0]       m_rx_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             m_start_q;
    logic [7:0]       m_tx_data_q;
    logic             seq_done_q;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q;
    logic [AW:0]   tx_cnt_q;
    logic          tx_push, tx_pop, tx_empty;
    logic          issue_fire;

    assign tx_wr_ready = (tx_cnt_q != FULL_CNT);
    assign tx_empty    = (tx_cnt_q == '0);
    assign tx_push     = tx_wr_valid && tx_wr_ready;
    assign issue_fire  = (state_q == ST_ISSUE) && !tx_empty && !m_busy;
    assign tx_pop      = issue_fire;

    // TX storage write; no reset needed, the count qualifies the contents
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr_q] <= tx_wr_data;
        end
    end

    // TX pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr_q <= tx_wptr_q + 1'b1;
            end
            if (tx_pop) begin
                tx_rptr_q <= tx_rptr_q + 1'b1;
            end
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------

    // Next-state and remaining-count logic
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    rem_d   = len;
                    state_d = (len == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_done) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                    // A zero count here would be illegal; end the burst rather than hang.
                    state_d = (rem_q <= LEN_W'(1)) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and remaining-byte counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Registered engine strobe, held TX byte and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_start_q   <= 1'b0;
            m_tx_data_q <= 8'h00;
            seq_done_q  <= 1'b0;
        end else begin
            m_start_q  <= issue_fire;
            seq_done_q <= (state_q == ST_FINISH);
            if (issue_fire) begin
                m_tx_data_q <= tx_mem[tx_rptr_q];
            end
        end
    end

    assign m_start   = m_start_q;
    assign m_tx_data = m_tx_data_q;
    assign seq_done  = seq_done_q;
    assign seq_busy  = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
`ifdef SPI_XFER_SEQ_RX_FIFO_EN
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_rptr_q;
    logic [AW:0]   rx_cnt_q;
    logic          rx_event, rx_full, rx_push, rx_pop;
    logic          rx_ovf_q;

    assign rx_event    = (state_q == ST_WAIT) && m_done;
    assign rx_full     = (rx_cnt_q == FULL_CNT);
    assign rx_push     = rx_event && !rx_full;
    assign rx_rd_valid = (rx_cnt_q != '0);
    assign rx_pop      = rx_rd_ready && rx_rd_valid;
    assign rx_rd_data  = rx_mem[rx_rptr_q];
    assign rx_ovf      = rx_ovf_q;

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr_q] <= m_rx_data;
        end
    end

    // RX pointers, occupancy and sticky overflow (cleared by the next accepted go)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            rx_ovf_q  <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wptr_q <= rx_wptr_q + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr_q <= rx_rptr_q + 1'b1;
            end
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase
            if ((state_q == ST_IDLE) && go) begin
                rx_ovf_q <= 1'b0;
            end else if (rx_event && rx_full) begin
                rx_ovf_q <= 1'b1;
            end
        end
    end
`else
    // No RX storage: received bytes are discarded.
    logic unused_rx;
    assign unused_rx   = ^{m_rx_data, rx_rd_ready};
    assign rx_rd_valid = 1'b0;
    assign rx_rd_data  = 8'h00;
    assign rx_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: directed self-checking bench for spi_xfer_seq.
// A behavioural byte engine loops each MOSI byte back as the received byte.
// RX-side expectations follow SPI_XFER_SEQ_RX_FIFO_EN.
`timescale 1ns/1ps
module tb_spi_xfer_seq;

    localparam int DEPTH   = 8;
    localparam int LEN_W   = 8;
    localparam int ENG_LAT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tx_wr_valid = 1'b0;
    logic [7:0]       tx_wr_data = 8'h00;
    logic             tx_wr_ready;
    logic             rx_rd_valid;
    logic [7:0]       rx_rd_data;
    logic             rx_rd_ready = 1'b0;
    logic             go = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             seq_busy, seq_done, rx_ovf;
    logic             m_start;
    logic [7:0]       m_tx_data;
    logic             m_busy;
    logic             m_done;
    logic [7:0]       m_rx_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_xfer_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_wr_valid(tx_wr_valid), .tx_wr_data(tx_wr_data), .tx_wr_ready(tx_wr_ready),
        .rx_rd_valid(rx_rd_valid), .rx_rd_data(rx_rd_data), .rx_rd_ready(rx_rd_ready),
        .go(go), .len(len),
        .seq_busy(seq_busy), .seq_done(seq_done), .rx_ovf(rx_ovf),
        .m_start(m_start), .m_tx_data(m_tx_data),
        .m_busy(m_busy), .m_done(m_done), .m_rx_data(m_rx_data)
    );

    // Byte engine model: busy for ENG_LAT+1 cycles after m_start, then loops the byte back.
    logic       eng_busy;
    int         eng_cnt;
    logic [7:0] eng_data;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_busy <= 1'b0; eng_cnt <= 0; eng_data <= 8'h00;
            m_done <= 1'b0; m_rx_data <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (eng_busy) begin
                if (eng_cnt == 0) begin
                    m_done <= 1'b1; m_rx_data <= eng_data; eng_busy <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end else if (m_start) begin
                eng_busy <= 1'b1; eng_cnt <= ENG_LAT; eng_data <= m_tx_data;
            end
        end
    end
    assign m_busy = eng_busy;

    // Monitors: log every issued byte, count completions and over-long start pulses.
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         long_cnt = 0;
    logic       m_start_prev = 1'b0;
    logic [7:0] tx_log [0:255];
    always @(posedge clk) begin
        if (m_start) begin
            tx_log[start_cnt[7:0]] <= m_tx_data;
            start_cnt <= start_cnt + 1;
        end
        if (m_start && m_start_prev) long_cnt <= long_cnt + 1;
        m_start_prev <= m_start;
        if (seq_done) done_cnt <= done_cnt + 1;
    end

    // ---------------- stimulus helpers (all entered/left at posedge+1) ----------------
    task automatic push(input logic [7:0] d);
        tx_wr_valid = 1'b1; tx_wr_data = d;
        @(posedge clk); #1;
        tx_wr_valid = 1'b0;
    endtask

    task automatic start(input logic [LEN_W-1:0] l);
        go = 1'b1; len = l;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic pop_rx();
        rx_rd_ready = 1'b1;
        @(posedge clk); #1;
        rx_rd_ready = 1'b0;
    endtask

    task automatic drain_rx();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (!rx_rd_valid) break;
            pop_rx();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (seq_done) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; #3;
        checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL rst_m_start got %b exp 0", m_start); end
        checks++; if (m_tx_data !== 8'h00) begin errors++; $display("FAIL rst_m_tx_data got %h exp 00", m_tx_data); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL rst_seq_done got %b exp 0", seq_done); end
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rst_seq_busy got %b exp 0", seq_busy); end
        checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL rst_rx_ovf got %b exp 0", rx_ovf); end
        checks++; if (rx_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", rx_rd_valid); end
        checks++; if (tx_wr_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b exp 1", tx_wr_ready); end
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_loopback();
        int s0, d0; bit ok;
        push(8'hA5); push(8'h3C);
        s0 = start_cnt; d0 = done_cnt;
        start(8'd2);
        checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL lb_early_start got %b exp 0", m_start); end
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL lb_busy got %b exp 1", seq_busy); end
        @(posedge clk); #1;
        checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL lb_latency_start got %b exp 1", m_start); end
        checks++; if (m_tx_data !== 8'hA5) begin errors++; $display("FAIL lb_first_byte got %h exp a5", m_tx_data); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lb_done got 0 exp 1"); end
        @(posedge clk); #1;
        checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL lb_starts got %0d exp 2", start_cnt - s0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL lb_dones got %0d exp 1", done_cnt - d0); end
        checks++; if (tx_log[s0+1] !== 8'h3C) begin errors++; $display("FAIL lb_second_byte got %h exp 3c", tx_log[s0+1]); end
        checks++; if (m_tx_data !== 8'h3C) begin errors++; $display("FAIL lb_tx_hold got %h exp 3c", m_tx_data); end
`ifdef SPI_XFER_SEQ_RX_FIFO_EN
        checks++; if (rx_rd_valid !== 1'b1 || rx_rd_data !== 8'hA5) begin errors++; $display("FAIL lb_rx0 got %b/%h exp 1/a5", rx_rd_valid, rx_rd_data); end
        pop_rx();
        checks++; if (rx_rd_valid !== 1'b1 || rx_rd_data !== 8'h3C) begin errors++; $display("FAIL lb_rx1 got %b/%h exp 1/3c", rx_rd_valid, rx_rd_data); end
        pop_rx();
        checks++; if (rx_rd_valid !== 1'b0) begin errors++; $display("FAIL lb_rx_empty got %b exp 0", rx_rd_valid); end
`else
        checks++; if (rx_rd_valid !== 1'b0 || rx_rd_data !== 8'h00) begin errors++; $display("FAIL lb_rx_off got %b/%h exp 0/00", rx_rd_valid, rx_rd_data); end
`endif
    endtask

    task automatic test_zero_len();
        int s0;
        s0 = start_cnt;
        start(8'd0);
        checks++; if (seq_busy !== 1'b1 || seq_done !== 1'b0) begin errors++; $display("FAIL z_cycle1 got busy %b done %b exp 1/0", seq_busy, seq_done); end
        @(posedge clk); #1;
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL z_done got %b exp 1", seq_done); end
        @(posedge clk); #1;
        checks++; if (seq_done !== 1'b0 || seq_busy !== 1'b0) begin errors++; $display("FAIL z_after got done %b busy %b exp 0/0", seq_done, seq_busy); end
        checks++; if (start_cnt != s0) begin errors++; $display("FAIL z_no_start got %0d exp 0", start_cnt - s0); end
    endtask

    task automatic test_stall();
        int s0, d0; bit ok;
        push(8'h11);
        s0 = start_cnt; d0 = done_cnt;
        start(8'd3);
        repeat (40) @(posedge clk);
        #1;
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL st_one_start got %0d exp 1", start_cnt - s0); end
        checks++; if (seq_busy !== 1'b1 || done_cnt != d0) begin errors++; $display("FAIL st_stalled got busy %b dones %0d exp 1/0", seq_busy, done_cnt - d0); end
        push(8'h22); push(8'h33);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL st_done got 0 exp 1"); end
        @(posedge clk); #1;
        checks++; if (start_cnt - s0 != 3) begin errors++; $display("FAIL st_starts got %0d exp 3", start_cnt - s0); end
        checks++; if (tx_log[s0+2] !== 8'h33) begin errors++; $display("FAIL st_third_byte got %h exp 33", tx_log[s0+2]); end
        drain_rx();
    endtask

    task automatic test_rx_ovf();
        bit ok;
        for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i));
        start(8'(DEPTH));
        wait_done(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ov_fill_done got 0 exp 1"); end
        push(8'hEE);
        start(8'd1);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ov_done got 0 exp 1"); end
        @(posedge clk); #1;
`ifdef SPI_XFER_SEQ_RX_FIFO_EN
        checks++; if (rx_ovf !== 1'b1) begin errors++; $display("FAIL ov_flag got %b exp 1", rx_ovf); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (rx_rd_valid !== 1'b1 || rx_rd_data !== 8'h40 + 8'(i)) begin
                errors++; $display("FAIL ov_keep%0d got %b/%h exp 1/%h", i, rx_rd_valid, rx_rd_data, 8'h40 + 8'(i));
            end
            pop_rx();
        end
        checks++; if (rx_rd_valid !== 1'b0) begin errors++; $display("FAIL ov_empty got %b exp 0", rx_rd_valid); end
        start(8'd0);
        checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL ov_clear got %b exp 0", rx_ovf); end
        wait_done(20, ok);
`else
        checks++; if (rx_ovf !== 1'b0 || rx_rd_valid !== 1'b0) begin errors++; $display("FAIL ov_off got %b/%b exp 0/0", rx_ovf, rx_rd_valid); end
`endif
    endtask

    task automatic test_tx_full();
        int s0, s1; bit ok, seen;
        logic [7:0] exp_b [0:7];
        for (int i = 0; i < DEPTH; i++) push(8'h60 + 8'(i));
        checks++; if (tx_wr_ready !== 1'b0) begin errors++; $display("FAIL tf_full got %b exp 0", tx_wr_ready); end
        push(8'h99);
        checks++; if (tx_wr_ready !== 1'b0) begin errors++; $display("FAIL tf_still_full got %b exp 0", tx_wr_ready); end
        s0 = start_cnt;
        start(8'd2);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_done) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL tf_first_done got 0 exp 1"); end
        // The second pop lands two edges after m_done; write on that same edge.
        @(posedge clk); #1;
        checks++; if (tx_wr_ready !== 1'b1) begin errors++; $display("FAIL tf_seven got %b exp 1", tx_wr_ready); end
        tx_wr_valid = 1'b1; tx_wr_data = 8'h77;
        @(posedge clk); #1;
        tx_wr_valid = 1'b0;
        checks++; if (m_start !== 1'b1) begin errors++; $display("FAIL tf_pop_edge got %b exp 1", m_start); end
        checks++; if (tx_wr_ready !== 1'b1) begin errors++; $display("FAIL tf_same_cnt got %b exp 1", tx_wr_ready); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tf_done got 0 exp 1"); end
        push(8'h88);
        checks++; if (tx_wr_ready !== 1'b0) begin errors++; $display("FAIL tf_refull got %b exp 0", tx_wr_ready); end
        checks++; if (tx_log[s0] !== 8'h60 || tx_log[s0+1] !== 8'h61) begin errors++; $display("FAIL tf_head got %h %h exp 60 61", tx_log[s0], tx_log[s0+1]); end
        drain_rx();
        for (int i = 0; i < 6; i++) exp_b[i] = 8'h62 + 8'(i);
        exp_b[6] = 8'h77; exp_b[7] = 8'h88;
        s1 = start_cnt;
        start(8'(DEPTH));
        wait_done(400, ok);
        @(posedge clk); #1;
        checks++; if (start_cnt - s1 != DEPTH) begin errors++; $display("FAIL tf_drain_cnt got %0d exp %0d", start_cnt - s1, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (tx_log[s1+i] !== exp_b[i]) begin
                errors++; $display("FAIL tf_order%0d got %h exp %h", i, tx_log[s1+i], exp_b[i]);
            end
        end
        drain_rx();
    endtask

    task automatic test_reset_mid();
        int s0, d0; bit ok, seen;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        d0 = done_cnt;
        start(8'd4);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_busy) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rm_wait_reached got 0 exp 1"); end
        #2; rst_n = 1'b0; #1;
        checks++; if (m_start !== 1'b0 || m_tx_data !== 8'h00) begin errors++; $display("FAIL rm_engine got %b/%h exp 0/00", m_start, m_tx_data); end
        checks++; if (seq_busy !== 1'b0 || seq_done !== 1'b0) begin errors++; $display("FAIL rm_seq got %b/%b exp 0/0", seq_busy, seq_done); end
        checks++; if (tx_wr_ready !== 1'b1 || rx_rd_valid !== 1'b0 || rx_ovf !== 1'b0) begin
            errors++; $display("FAIL rm_fifos got %b/%b/%b exp 1/0/0", tx_wr_ready, rx_rd_valid, rx_ovf);
        end
        repeat (3) @(posedge clk);
        #3; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rm_no_done got %0d exp 0", done_cnt - d0); end
        push(8'h5A);
        s0 = start_cnt;
        start(8'd1);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_new_done got 0 exp 1"); end
        @(posedge clk); #1;
        checks++; if (start_cnt - s0 != 1 || tx_log[s0] !== 8'h5A) begin
            errors++; $display("FAIL rm_new_byte got %0d/%h exp 1/5a", start_cnt - s0, tx_log[s0]);
        end
`ifdef SPI_XFER_SEQ_RX_FIFO_EN
        checks++; if (rx_rd_valid !== 1'b1 || rx_rd_data !== 8'h5A) begin errors++; $display("FAIL rm_rx got %b/%h exp 1/5a", rx_rd_valid, rx_rd_data); end
        drain_rx();
`endif
    endtask

    task automatic test_pulse_width();
        checks++; if (long_cnt != 0) begin errors++; $display("FAIL m_start_width got %0d long pulses exp 0", long_cnt); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_zero_len();
        test_stall();
        test_rx_ovf();
        test_tx_full();
        test_reset_mid();
        test_pulse_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
